// File: rtl/kbd_input_ctrl.sv
// kbd_input_ctrl: PS/2 key capture into a FIFO with a CPU read handshake and optional digit display tracking (KBD_ECHO_DISP_EN); ports CLK/RESET, KEY_WRITE/KEY_CODE in, RD_REQ in -> RD_ACK/RD_DATA out, COUNT/FULL/EMPTY status, DISP_LAST/DISP_PREV nibbles.
module kbd_input_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_WRITE,
  input  logic [4:0] KEY_CODE,
  input  logic       RD_REQ,
  output logic [7:0] RD_DATA,
  output logic       RD_ACK,
  output logic [4:0] COUNT,
  output logic       FULL,
  output logic       EMPTY,
  output logic [3:0] DISP_LAST,
  output logic [3:0] DISP_PREV
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK, WAIT_REL} state_t;
  state_t state_q, state_d;
  logic kw_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [4:0] cnt_q, cnt_d;
  logic ovr_q, ovr_d;
  logic [4:0] mem_q [DEPTH];
  logic key_rise, clr, push, pop, drop, in_ack;
  always_comb begin
    key_rise = KEY_WRITE & ~kw_q;
    clr = key_rise & (KEY_CODE == 5'h1F);
    in_ack = state_q == ACK;
    pop = in_ack & ~EMPTY & ~clr;
    push = key_rise & ~clr & (~FULL | pop);
    drop = key_rise & ~clr & FULL & ~pop;
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = RD_REQ ? ACK : IDLE;
      ACK:      state_d = WAIT_REL;
      default:  state_d = RD_REQ ? WAIT_REL : IDLE;
    endcase
    RD_ACK = in_ack & ~RESET;
    RD_DATA = RD_ACK ? {~EMPTY & ~clr, ovr_q, 1'b0, (EMPTY | clr) ? 5'h00 : mem_q[rd_q]} : 8'h00;
    wr_d = clr ? '0 : wr_q + AW'(push);
    rd_d = clr ? '0 : rd_q + AW'(pop);
    cnt_d = clr ? 5'd0 : cnt_q + 5'(push) - 5'(pop);
    ovr_d = drop ? 1'b1 : in_ack ? 1'b0 : ovr_q;
    COUNT = cnt_q;
    FULL = cnt_q == 5'(DEPTH);
    EMPTY = cnt_q == 5'd0;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      kw_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= 5'd0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kw_q <= KEY_WRITE;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      ovr_q <= ovr_d;
    end
  end
  always_ff @(posedge CLK) if (push) mem_q[wr_q] <= KEY_CODE;
`ifdef KBD_ECHO_DISP_EN
  logic [3:0] last_q, last_d, prev_q, prev_d;
  logic digit;
  always_comb begin
    digit = key_rise & ~KEY_CODE[4];
    last_d = clr ? 4'h0 : digit ? KEY_CODE[3:0] : last_q;
    prev_d = clr ? 4'h0 : digit ? last_q : prev_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_q <= 4'h0;
      prev_q <= 4'h0;
    end else begin
      last_q <= last_d;
      prev_q <= prev_d;
    end
  end
  assign DISP_LAST = last_q;
  assign DISP_PREV = prev_q;
`else
  assign DISP_LAST = 4'h0;
  assign DISP_PREV = 4'h0;
`endif
endmodule

// File: tb/tb_kbd_input_ctrl.sv
// tb_kbd_input_ctrl: directed table plus corner-case sequences for kbd_input_ctrl.
module tb_kbd_input_ctrl;
  logic CLK = 1'b0;
  logic RESET, KEY_WRITE, RD_REQ;
  logic [4:0] KEY_CODE;
  logic [7:0] RD_DATA;
  logic RD_ACK, FULL, EMPTY;
  logic [4:0] COUNT;
  logic [3:0] DISP_LAST, DISP_PREV;
  int total = 0, bad = 0;
`ifdef KBD_ECHO_DISP_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif
  kbd_input_ctrl #(.DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .KEY_WRITE(KEY_WRITE), .KEY_CODE(KEY_CODE),
    .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_ACK(RD_ACK), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .DISP_LAST(DISP_LAST), .DISP_PREV(DISP_PREV)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic kw; logic [4:0] code; logic rd; int n;
    int cnt; logic ack; logic [7:0] data; logic [3:0] last; logic [3:0] prev;
  } vec_t;
  vec_t tv[14];
  function automatic logic [3:0] d(input logic [3:0] v);
    return ECHO ? v : 4'h0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    RESET = 1'b1; KEY_WRITE = 1'b0; KEY_CODE = 5'h00; RD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask
  task automatic key(input logic [4:0] c);
    KEY_CODE = c; KEY_WRITE = 1'b1;
    @(negedge CLK);
    KEY_WRITE = 1'b0;
    @(negedge CLK);
  endtask
  task automatic rd_txn(output logic [7:0] dv);
    bit got;
    got = 1'b0; dv = 8'h00; RD_REQ = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge CLK);
      if (RD_ACK) begin got = 1'b1; dv = RD_DATA; end
    end
    chk("rd_ack_seen", 32'(got), 1);
    RD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
  endtask
  initial begin
    logic [7:0] dv;
    int acks;
    tv[0]  = '{1'b1, 5'h07, 1'b0, 10, 1, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[1]  = '{1'b0, 5'h00, 1'b1, 1,  1, 1'b1, 8'h87, d(4'h7), d(4'h0)};
    tv[2]  = '{1'b0, 5'h00, 1'b1, 1,  0, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[3]  = '{1'b0, 5'h00, 1'b1, 18, 0, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[4]  = '{1'b0, 5'h00, 1'b0, 1,  0, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[5]  = '{1'b0, 5'h00, 1'b1, 1,  0, 1'b1, 8'h00, d(4'h7), d(4'h0)};
    tv[6]  = '{1'b0, 5'h00, 1'b0, 2,  0, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[7]  = '{1'b1, 5'h12, 1'b0, 1,  1, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[8]  = '{1'b0, 5'h00, 1'b0, 1,  1, 1'b0, 8'h00, d(4'h7), d(4'h0)};
    tv[9]  = '{1'b1, 5'h09, 1'b0, 1,  2, 1'b0, 8'h00, d(4'h9), d(4'h7)};
    tv[10] = '{1'b0, 5'h00, 1'b1, 1,  2, 1'b1, 8'h92, d(4'h9), d(4'h7)};
    tv[11] = '{1'b0, 5'h00, 1'b0, 2,  1, 1'b0, 8'h00, d(4'h9), d(4'h7)};
    tv[12] = '{1'b0, 5'h00, 1'b1, 1,  1, 1'b1, 8'h89, d(4'h9), d(4'h7)};
    tv[13] = '{1'b0, 5'h00, 1'b0, 2,  0, 1'b0, 8'h00, d(4'h9), d(4'h7)};
    do_reset();
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_full", 32'(FULL), 0);
    chk("rst_ack", 32'(RD_ACK), 0);
    chk("rst_data", 32'(RD_DATA), 0);
    chk("rst_disp", 32'({DISP_LAST, DISP_PREV}), 0);
    for (int i = 0; i < 14; i++) begin
      KEY_WRITE = tv[i].kw; KEY_CODE = tv[i].code; RD_REQ = tv[i].rd;
      repeat (tv[i].n) @(negedge CLK);
      chk($sformatf("v%0d_count", i), 32'(COUNT), 32'(tv[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(EMPTY), 32'(tv[i].cnt == 0));
      chk($sformatf("v%0d_full", i), 32'(FULL), 32'(tv[i].cnt == 8));
      chk($sformatf("v%0d_ack", i), 32'(RD_ACK), 32'(tv[i].ack));
      chk($sformatf("v%0d_data", i), 32'(RD_DATA), 32'(tv[i].data));
      chk($sformatf("v%0d_last", i), 32'(DISP_LAST), 32'(tv[i].last));
      chk($sformatf("v%0d_prev", i), 32'(DISP_PREV), 32'(tv[i].prev));
    end
    do_reset();
    for (int k = 1; k <= 9; k++) key(5'(k));
    chk("ovr_count", 32'(COUNT), 8);
    chk("ovr_full", 32'(FULL), 1);
    rd_txn(dv);
    chk("ovr_first", 32'(dv), 32'h C1);
    chk("ovr_count7", 32'(COUNT), 7);
    rd_txn(dv);
    chk("ovr_second", 32'(dv), 32'h82);
    do_reset();
    key(5'h0A); key(5'h0B); key(5'h0C);
    acks = 0; dv = 8'h00; RD_REQ = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (RD_ACK) begin acks++; dv = RD_DATA; end
    end
    RD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    chk("hold_acks", 32'(acks), 1);
    chk("hold_count", 32'(COUNT), 2);
    chk("hold_data", 32'(dv), 32'h8A);
    do_reset();
    for (int k = 1; k <= 8; k++) key(5'(k));
    RD_REQ = 1'b1;
    @(negedge CLK);
    chk("simul_ack", 32'(RD_ACK), 1);
    chk("simul_data", 32'(RD_DATA), 32'h81);
    KEY_CODE = 5'h10; KEY_WRITE = 1'b1;
    @(negedge CLK);
    chk("simul_count", 32'(COUNT), 8);
    KEY_WRITE = 1'b0; RD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    rd_txn(dv);
    chk("simul_no_ovr", 32'(dv), 32'h82);
    do_reset();
    key(5'h03); key(5'h05);
    chk("clr_last_pre", 32'(DISP_LAST), 32'(d(4'h5)));
    chk("clr_prev_pre", 32'(DISP_PREV), 32'(d(4'h3)));
    chk("clr_count_pre", 32'(COUNT), 2);
    key(5'h1F);
    chk("clr_count", 32'(COUNT), 0);
    chk("clr_empty", 32'(EMPTY), 1);
    chk("clr_last", 32'(DISP_LAST), 0);
    chk("clr_prev", 32'(DISP_PREV), 0);
    key(5'h04);
    RD_REQ = 1'b1;
    @(negedge CLK);
    KEY_CODE = 5'h1F; KEY_WRITE = 1'b1;
    #1;
    chk("clrpop_ack", 32'(RD_ACK), 1);
    chk("clrpop_data", 32'(RD_DATA), 32'h00);
    @(negedge CLK);
    chk("clrpop_count", 32'(COUNT), 0);
    KEY_WRITE = 1'b0; RD_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    key(5'h06);
    chk("mid_count_pre", 32'(COUNT), 1);
    RD_REQ = 1'b1; RESET = 1'b1; KEY_CODE = 5'h02; KEY_WRITE = 1'b1;
    @(negedge CLK);
    chk("mid_ack", 32'(RD_ACK), 0);
    chk("mid_count", 32'(COUNT), 0);
    RESET = 1'b0; RD_REQ = 1'b0;
    @(negedge CLK);
    chk("mid_ack2", 32'(RD_ACK), 0);
    chk("post_rst_edge", 32'(COUNT), 1);
    KEY_WRITE = 1'b0;
    rd_txn(dv);
    chk("post_rst_data", 32'(dv), 32'h82);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
